// File: rtl/fp_acc.sv
// rtl/fp_acc.sv - streaming saturating fixed-point accumulator with burst framing
//
// Sums a burst of N-bit two's complement Q-format products in an (N+G)-bit
// guard-extended accumulator and emits one saturated N-bit result per burst.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input beat valid
//   in_ready   block can accept a beat (registered, depends on state only)
//   in_data    N-bit product, two's complement Q format
//   in_ovf     upstream overflow flag for this beat
//   in_last    final beat of the burst
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   N-bit saturated sum, same Q format
//   out_ovf    sticky overflow for the burst (accumulator clamp, output clamp or in_ovf)
//   out_count  number of terms accumulated, saturating at 2^CW-1
module fp_acc #(
  parameter int Q  = 6,
  parameter int N  = 16,
  parameter int G  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_ovf,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_ovf,
  output logic [CW-1:0] out_count
);

  localparam int AW = N + G;

  // The binary point passes through untouched; Q only has to be sane.
  if (Q >= N) begin : g_bad_q
    $error("fp_acc: Q must be smaller than N");
  end

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [N-1:0]  OUT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  OUT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {ACC, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic [AW:0]   sum_wide;
  logic          acc_clamp;
  logic [AW-1:0] acc_next;
  logic [CW-1:0] cnt_next;
  logic          ovf_next;
  logic          out_clamp;
  logic [N-1:0]  out_sat;
  logic          accept;

  assign accept = in_valid && in_ready;

  // One extra bit above the accumulator exposes signed overflow of the add:
  // the top two bits of the wide sum disagree exactly when the result left
  // the (N+G)-bit range.
  assign sum_wide  = {acc[AW-1], acc} + {{(G+1){in_data[N-1]}}, in_data};
  assign acc_clamp = sum_wide[AW] ^ sum_wide[AW-1];
  assign acc_next  = acc_clamp ? (sum_wide[AW] ? ACC_MIN : ACC_MAX) : sum_wide[AW-1:0];

  assign cnt_next  = (&cnt) ? cnt : cnt + 1'b1;
  assign ovf_next  = ovf | in_ovf | acc_clamp;

  // The accumulator fits in N bits only when every bit from N-1 upward is a
  // copy of the sign.
  assign out_clamp = !((&acc_next[AW-1:N-1]) || !(|acc_next[AW-1:N-1]));
  assign out_sat   = out_clamp ? (acc_next[AW-1] ? OUT_MIN : OUT_MAX) : acc_next[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        ACC: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (in_last) begin
              out_data  <= out_sat;
              out_ovf   <= ovf_next | out_clamp;
              out_count <= cnt_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_acc.sv
// tb/tb_fp_acc.sv - scoreboard testbench for fp_acc
module tb_fp_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_ovf;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [7:0]  out_count;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
    logic [7:0]  c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fp_acc #(.Q(6), .N(16), .G(4), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ovf   (in_ovf),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got data 0x%0h with empty scoreboard", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data",  {16'h0, out_data},  {16'h0, e.d});
        check("out_ovf",   {31'h0, out_ovf},   {31'h0, e.o});
        check("out_count", {24'h0, out_count}, {24'h0, e.c});
      end
    end
  end

  task automatic expect_out(input logic [15:0] d, input logic o, input logic [7:0] c);
    exp_t e;
    e.d = d; e.o = o; e.c = c;
    sb.push_back(e);
  endtask

  // Present one beat from a negedge; it is taken on the next posedge where in_ready is high.
  task automatic send_beat(input logic [15:0] d, input logic ov, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_ovf = ov; in_last = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_ovf = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_rep(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) send_beat(d, 1'b0, (i == n - 1));
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'h0, in_ready},  32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data",  {16'h0, out_data},  32'd0);
    check("rst_out_ovf",   {31'h0, out_ovf},   32'd0);
    check("rst_out_count", {24'h0, out_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'h0, in_ready}, 32'd1);

    // Basic sum: 1.0 + 2.0 - 1.0 = 2.0; out_valid high for exactly one cycle.
    expect_out(16'h0080, 1'b0, 8'd3);
    send_beat(16'h0040, 1'b0, 1'b0);
    send_beat(16'h0080, 1'b0, 1'b0);
    send_beat(16'hFFC0, 1'b0, 1'b1);
    @(negedge clk);
    check("basic_valid_rise", {31'h0, out_valid}, 32'd1);
    @(negedge clk);
    check("basic_valid_fall", {31'h0, out_valid}, 32'd0);
    drain();

    // Output saturation in both directions.
    expect_out(16'h7FFF, 1'b1, 8'd4);
    send_rep(16'h7000, 4);
    drain();
    expect_out(16'h8000, 1'b1, 8'd4);
    send_rep(16'h9000, 4);
    drain();

    // Guard bits absorb the intermediate excursion.
    expect_out(16'h7FFF, 1'b0, 8'd3);
    send_beat(16'h7FFF, 1'b0, 1'b0);
    send_beat(16'h7FFF, 1'b0, 1'b0);
    send_beat(16'h8001, 1'b0, 1'b1);
    drain();

    // Backpressure with upstream overflow on beat 2: 0x0100+0x0200+0x0040.
    out_ready = 1'b0;
    expect_out(16'h0340, 1'b1, 8'd3);
    send_beat(16'h0100, 1'b0, 1'b0);
    send_beat(16'h0200, 1'b1, 1'b0);
    send_beat(16'h0040, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'h0, out_valid}, 32'd1);
      check("bp_out_data",  {16'h0, out_data},  32'h0340);
      check("bp_in_ready",  {31'h0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    drain();
    expect_out(16'h0040, 1'b0, 8'd1);
    send_beat(16'h0040, 1'b0, 1'b1);
    drain();

    // Count saturation.
    expect_out(16'h0000, 1'b0, 8'd255);
    send_rep(16'h0000, 300);
    drain();

    // Reset mid-burst discards the partial sum.
    send_beat(16'h1000, 1'b0, 1'b0);
    send_beat(16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out(16'h0040, 1'b0, 8'd1);
    send_beat(16'h0040, 1'b0, 1'b1);
    drain();

    // Reset while holding an unaccepted result.
    out_ready = 1'b0;
    send_beat(16'h0040, 1'b0, 1'b1);
    @(negedge clk);
    check("hold_out_valid", {31'h0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("hold_rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("hold_rst_out_count", {24'h0, out_count}, 32'd0);
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
